// File: rtl/uart_bridge_pkg.sv
// Shared types and defaults for the UART byte bridge: FSM states, transmit mode
// and the default fill byte.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } bridge_state_t;

  typedef enum logic {
    MODE_DRAIN,
    MODE_FILL
  } bridge_mode_t;

  localparam logic [7:0] DEFAULT_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read, occupancy count and
// modulo-DEPTH pointers. Callers gate push/pop against full/empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;

  // Storage carries no reset; only pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/uart_byte_bridge.sv
// Byte queue between UART RX and TX: buffers received bytes, drains them on
// send, or transmits a single fill byte on load_fill, using the TX busy handshake.
module uart_byte_bridge
  import uart_bridge_pkg::*;
#(
  parameter int                 DATA_W    = 8,
  parameter int                 DEPTH     = 16,
  parameter logic [DATA_W-1:0]  FILL_BYTE = DATA_W'(DEFAULT_FILL_BYTE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [DATA_W-1:0]      rx_data,
  input  logic                   send,
  input  logic                   load_fill,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
);

  bridge_state_t     r_state, w_state_nxt;
  bridge_mode_t      r_mode, w_mode_nxt;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_overflow;

  assign w_pop  = w_issue && (r_mode == MODE_DRAIN) && !w_empty;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign w_push = rx_valid && (!w_full || w_pop);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (rx_data),
    .rdata (w_head),
    .count (count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_DRAIN;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (send && !w_empty) begin
          w_state_nxt = ST_ISSUE;
          w_mode_nxt  = MODE_DRAIN;
        end else if (load_fill && !send) begin
          w_state_nxt = ST_ISSUE;
          w_mode_nxt  = MODE_FILL;
        end
      end
      ST_ISSUE: begin
        if (!tx_busy) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A byte arriving on the final cycle still continues the drain.
        if (!tx_busy) begin
          if ((r_mode == MODE_DRAIN) && (!w_empty || w_push)) begin
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_start <= w_issue;
      if (w_issue) begin
        r_tx_data <= (r_mode == MODE_DRAIN) ? w_head : FILL_BYTE;
      end
      if (rx_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Scoreboard bench for uart_byte_bridge: expected TX bytes are queued at
// stimulus time and checked by a monitor on every tx_start pulse.
module tb_uart_byte_bridge;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              send;
  logic              load_fill;
  logic              tx_busy;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic [4:0]        count;
  logic              empty;
  logic              full;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;
  bit tx_en    = 1'b1;
  logic [DATA_W-1:0] exp_q [$];

  uart_byte_bridge #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .FILL_BYTE (8'hFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .send      (send),
    .load_fill (load_fill),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmitter model: busy for 10 cycles after each start pulse.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && tx_en) begin
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: every start pulse consumes one expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        n_starts++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_tx_start: got data %0h expected no pulse", tx_data);
        end else begin
          logic [DATA_W-1:0] e;
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            n_errors++;
            $display("FAIL tx_data: got %0h expected %0h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic push_byte(input logic [DATA_W-1:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_send();
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (15) tick();
  endtask

  task automatic wait_starts(input int target, input string name);
    int budget = 500;
    while (n_starts < target && budget > 0) begin
      tick();
      budget--;
    end
    chk({name, "_starts"}, n_starts, target);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0; send = 1'b0; load_fill = 1'b0;

    // Basic drain of three bytes, including send-to-start latency
    do_reset();
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    chk("count_after_3", {27'b0, count}, 32'd3);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    pulse_send();
    chk("latency_not_yet", {31'b0, tx_start}, 32'd0);
    tick();
    chk("latency_start", {31'b0, tx_start}, 32'd1);
    wait_drain("drain3");
    chk("drain3_empty", {31'b0, empty}, 32'd1);

    // Overflow: 18 bytes into a 16-entry FIFO
    rx_valid = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      rx_data = 8'(i);
      if (i < DEPTH) exp_q.push_back(8'(i));
      tick();
    end
    rx_valid = 1'b0;
    chk("ovf_full", {31'b0, full}, 32'd1);
    chk("ovf_count", {27'b0, count}, 32'd16);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
    pulse_send();
    wait_drain("ovf_drain");
    chk("ovf_drain_empty", {31'b0, empty}, 32'd1);
    chk("ovf_sticky", {31'b0, overflow}, 32'd1);
    do_reset();

    // Fill byte on empty FIFO, then send on empty is ignored
    exp_q.push_back(8'hFF);
    load_fill = 1'b1;
    tick();
    load_fill = 1'b0;
    wait_drain("fill");
    chk("fill_count", {27'b0, count}, 32'd0);
    base = n_starts;
    pulse_send();
    repeat (20) tick();
    chk("send_empty_ignored", n_starts, base);

    // Byte injected during WAIT_DONE of last byte joins the drain
    push_byte(8'h60); push_byte(8'h61);
    exp_q.push_back(8'h60); exp_q.push_back(8'h61); exp_q.push_back(8'h55);
    base = n_starts;
    pulse_send();
    wait_starts(base + 2, "inject");
    repeat (3) tick();
    push_byte(8'h55);
    wait_drain("inject");
    chk("inject_empty", {31'b0, empty}, 32'd1);

    // Full FIFO with rx_valid coincident with the pop at ISSUE
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'h80 + 8'(i));
      exp_q.push_back(8'h80 + 8'(i));
    end
    exp_q.push_back(8'h90);
    chk("coinc_full_before", {31'b0, full}, 32'd1);
    pulse_send();
    rx_valid = 1'b1;
    rx_data  = 8'h90;
    tick();
    rx_valid = 1'b0;
    chk("coinc_start", {31'b0, tx_start}, 32'd1);
    chk("coinc_count", {27'b0, count}, 32'd16);
    chk("coinc_overflow", {31'b0, overflow}, 32'd0);
    wait_drain("coinc");
    chk("coinc_empty", {31'b0, empty}, 32'd1);

    // Reset in WAIT_BUSY with 4 bytes still queued
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
    exp_q.push_back(8'hA0);
    base = n_starts;
    pulse_send();
    wait_starts(base + 1, "midrst");
    tick();
    chk("midrst_count_before", {27'b0, count}, 32'd4);
    rst_n = 1'b0;
    tick();
    chk("midrst_count", {27'b0, count}, 32'd0);
    chk("midrst_tx_start", {31'b0, tx_start}, 32'd0);
    chk("midrst_tx_data", {24'b0, tx_data}, 32'd0);
    chk("midrst_overflow", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    tx_en = 1'b1;
    base = n_starts;
    pulse_send();
    repeat (20) tick();
    chk("midrst_send_ignored", n_starts, base);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_bridge.md
# uart_byte_bridge

Parametrised byte buffer between the UART receiver and transmitter in the board top level. Received bytes are queued in an internal FIFO. A debounced `send` pulse drains the whole queue to the transmitter, one byte per frame, using the transmitter's busy handshake. A `load_fill` pulse sends one fixed fill byte, which replaces the old button-loads-0xFF behaviour. Overflow and occupancy are reported for LEDs/debug.

## Interface
Parameters:
- `DATA_W`, 8, byte width on RX/TX paths.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `FILL_BYTE`, 8'hFF, byte sent on `load_fill` (width `DATA_W`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `rx_valid`  in  1  one-cycle pulse: `rx_data` is valid (receiver ready strobe).
- `rx_data`  in  DATA_W  received byte.
- `send`  in  1  one-cycle debounced pulse: drain the FIFO.
- `load_fill`  in  1  one-cycle debounced pulse: send `FILL_BYTE` once.
- `tx_busy`  in  1  transmitter busy.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmit.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `empty`  out  1  count==0.
- `full`  out  1  count==DEPTH.
- `overflow`  out  1  sticky; set when a byte is dropped.

## Operation
- Write: on `rx_valid`, push `rx_data` if not full, or if a pop happens in the same cycle.
  - Otherwise drop the byte and set `overflow`.
  - `overflow` clears only on reset.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - `send` with !empty → ISSUE, drain mode.
  - `load_fill` (with `send` low) → ISSUE, fill mode.
  - `send` while empty is ignored.
  - `send` and `load_fill` in the same cycle: `send` wins.
- ISSUE: waits until `tx_busy`==0, then in that cycle:
  - asserts `tx_start`;
  - loads `tx_data` with the FIFO head (drain mode, with pop) or `FILL_BYTE` (fill mode, no pop);
  - → WAIT_BUSY.
- WAIT_BUSY: → WAIT_DONE when `tx_busy`==1.
- WAIT_DONE: when `tx_busy`==0:
  - drain mode and !empty → ISSUE;
  - otherwise → IDLE.
- Bytes received during a drain join the queue and are transmitted in the same drain.
- `send`/`load_fill` outside IDLE are ignored, not queued.
- Width rule: `count` increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, FSM=IDLE, pointers=0.
- Reset mid-operation:
  - the FIFO is flushed and the FSM returns to IDLE on the next edge;
  - a frame already started in the transmitter completes outside this block.
- `tx_start` and `tx_data` are registered.
  - `tx_data` is stable from the `tx_start` cycle until the next `tx_start`.
- Latency, `send` to first `tx_start`: 2 cycles when `tx_busy`=0 (IDLE→ISSUE edge, then the registered pulse).
- Consecutive frames are separated by the transmitter's busy period plus 2 cycles.
- Push is visible in `count`/`empty` one cycle after `rx_valid`.
- Full + `rx_valid` + pop in the same cycle: byte accepted, `count` stays DEPTH, no overflow.
- Empty + `rx_valid` during WAIT_DONE: the byte is accepted and sent in the same drain.
- `tx_busy` stuck low after `tx_start`: the FSM waits in WAIT_BUSY indefinitely. This is a transmitter fault and is out of scope.

## Structure
- Package `uart_bridge_pkg`:
  - FSM state enum `bridge_state_t`;
  - mode enum (DRAIN, FILL);
  - default `FILL_BYTE` constant.
- Sub-module `sync_fifo` (params `DATA_W`, `DEPTH`):
  - ports `clk`, `rst_n`, `push`, `pop`, `wdata`, `rdata` (head, combinational read), `count`, `full`, `empty`.
- Top of block: FSM, overflow flag, output registers.

## Test plan
- Reset, then push 8'h41, 8'h42, 8'h43; pulse `send`; model `tx_busy` high 10 cycles after each start → three `tx_start` pulses with `tx_data` 41, 42, 43 in order, then `empty`=1, FSM IDLE.
- Push DEPTH+2 bytes (0..17) with no `send` → `full`=1, `count`=16, `overflow`=1; drain yields 0..15 only.
- `load_fill` with empty FIFO → one `tx_start`, `tx_data`=8'hFF, `count` stays 0. `send` while empty → no `tx_start`.
- During a drain of 2 bytes, inject `rx_valid` 8'h55 in WAIT_DONE of the last byte → 8'h55 is transmitted third in the same drain.
- Full FIFO, `rx_valid` coincident with a pop at ISSUE → `count` stays 16, `overflow` stays 0.
- Assert `rst_n`=0 in WAIT_BUSY with 4 bytes queued → next edge `count`=0, `tx_start`=0, `tx_data`=0, `overflow`=0; a following `send` is ignored.
